pattern_scan_ctrl: RTL and testbench
====================================

PATTERN_SCAN_CTRL -- requirements
Module: pattern_scan_ctrl

Interface
REQ-001 Parameter WORD_W, default 8: width of each input word, serialized MSB-first.
REQ-002 Parameter PAT_MAX, default 8: maximum pattern length in bits.
REQ-003 Parameter CNT_W, default 16: match counter width.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 cfg_we  in  1  load cfg_pattern/cfg_len/cfg_overlap (IDLE only).
REQ-007 cfg_pattern  in  PAT_MAX  target pattern; bit 0 is the most recent bit.
REQ-008 cfg_len  in  4  pattern length; legal 1..PAT_MAX.
REQ-009 cfg_overlap  in  1  1 = overlapping matches, 0 = non-overlapping.
REQ-010 start  in  1  IDLE->RUN; clears history, fill count and match counter.
REQ-011 stop  in  1  request return to IDLE after the current word.
REQ-012 word_valid  in  1  word_data valid.
REQ-013 word_data  in  WORD_W  word to scan.
REQ-014 word_ready  out  1  controller accepts word_data this cycle.
REQ-015 y  out  1  one-cycle match pulse.
REQ-016 match_count  out  CNT_W  number of matches since start, saturating.
REQ-017 busy  out  1  high in any state other than IDLE.
REQ-018 err  out  1  sticky config error flag.

Function
REQ-019 FSM states SHALL be IDLE, RUN and DRAIN.
- IDLE: start -> RUN.
- RUN: stop -> DRAIN.
- DRAIN: bits_left==0 -> IDLE.
REQ-020 A word SHALL transfer on a rising edge where word_valid && word_ready; word_data is captured into the shift register and bits_left is set to WORD_W.
REQ-021 word_ready SHALL be high only in RUN, and only when bits_left is 0 or 1; this gives back-to-back words with no bubble. word_ready SHALL be low in IDLE and DRAIN.
REQ-022 While bits_left>0, each edge SHALL shift one bit, MSB first, into hist (hist <= {hist[PAT_MAX-2:0], bit}), decrement bits_left and increment fill (fill saturates at PAT_MAX).
REQ-023 A match SHALL occur when a bit is shifted, fill (after update) >= cfg_len, and hist[cfg_len-1:0] == cfg_pattern[cfg_len-1:0].
REQ-024 y SHALL be registered and high for exactly the one cycle following the edge at which the completing bit enters hist; match_count increments on that same edge.
REQ-025 On a match with cfg_overlap=0, fill SHALL reset to 0, so the next match needs cfg_len fresh bits. With cfg_overlap=1, fill is kept.
REQ-026 match_count SHALL saturate at all-ones and not wrap.
REQ-027 cfg_we in IDLE with cfg_len of 0 or greater than PAT_MAX SHALL leave the configuration unchanged and set err.
REQ-028 cfg_we outside IDLE SHALL be ignored and set err.
REQ-029 err SHALL clear only on rst or on start.
REQ-030 hist and fill SHALL persist across word boundaries, so patterns may span words.
REQ-031 start outside IDLE SHALL be ignored. stop in IDLE SHALL be ignored. start and stop together in IDLE -> RUN.
REQ-032 stop seen on the same edge as a word transfer: that word SHALL be fully shifted before IDLE.
REQ-033 In IDLE, match_count SHALL hold its value; y SHALL be 0.

Reset
REQ-034 On rst, asynchronously and regardless of clk: state=IDLE, bits_left=0, hist=0, fill=0, y=0, match_count=0, word_ready=0, busy=0, err=0.
REQ-035 On rst, configuration SHALL reset to cfg_pattern=1011b (zero-extended), cfg_len=4, cfg_overlap=1.
REQ-036 rst asserted mid-word SHALL discard remaining bits. The first edge after release SHALL see IDLE.

Verification
REQ-037 Reset defaults, start, word 8'b1011_0110 -> y pulses after bits 4 and 7, match_count=2.
REQ-038 cfg_overlap=0, start, same word -> single y after bit 4, match_count=1.
REQ-039 Two back-to-back words 8'b0000_0101, 8'b1000_0000 with word_valid held -> word_ready high on each final-bit cycle, no bubble; match across the boundary (bits 1,0,1,1) -> match_count=1.
REQ-040 cfg_we with cfg_len=0 in IDLE -> err=1, configuration unchanged; cfg_we during RUN -> err=1; start -> err=0.
REQ-041 stop asserted 3 bits into a word -> busy stays 1 for 5 more shift cycles, word_ready stays 0, then IDLE.
REQ-042 rst pulsed mid-word with CNT_W=2 after reaching count 3 -> all outputs 0 immediately; separately, a further match at count 3 holds match_count=3 (saturation).

Source files
------------

// File: rtl/pattern_scan_ctrl.sv
// pattern_scan_ctrl: serialises input words MSB-first into a history
// register and pulses y whenever the newest cfg_len bits equal the
// configured pattern. Matches may span word boundaries; overlap mode
// decides whether a match consumes the bits it used.
`timescale 1ns/1ps
module pattern_scan_ctrl #(
  parameter int WORD_W  = 8,
  parameter int PAT_MAX = 8,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [PAT_MAX-1:0] cfg_pattern,
  input  logic [3:0]         cfg_len,
  input  logic               cfg_overlap,
  input  logic               start,
  input  logic               stop,
  input  logic               word_valid,
  input  logic [WORD_W-1:0]  word_data,
  output logic               word_ready,
  output logic               y,
  output logic [CNT_W-1:0]   match_count,
  output logic               busy,
  output logic               err
);

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] RUN   = 2'b01;
  localparam logic [1:0] DRAIN = 2'b10;

  localparam int BL_W = $clog2(WORD_W + 1);
  localparam logic [BL_W-1:0] WORD_W_BL = BL_W'(WORD_W);
  localparam logic [BL_W-1:0] BL_ONE    = BL_W'(1);
  localparam logic [3:0]      PAT_MAX4  = 4'(PAT_MAX);

  // Ones in the low len bit positions; selects the compared part of hist.
  function automatic logic [PAT_MAX-1:0] len_mask(input logic [3:0] len);
    logic [PAT_MAX-1:0] m;
    m = '0;
    for (int i = 0; i < PAT_MAX; i++) begin
      if (i < int'(len)) begin
        m[i] = 1'b1;
      end else begin
        m[i] = 1'b0;
      end
    end
    return m;
  endfunction

  logic [1:0]         state_r, state_s;
  logic [BL_W-1:0]    bits_left_r, bits_left_s;
  logic [WORD_W-1:0]  sreg_r, sreg_s;
  logic [PAT_MAX-1:0] hist_r, hist_s;
  logic [3:0]         fill_r, fill_s;
  logic [PAT_MAX-1:0] pat_r, pat_s;
  logic [3:0]         len_r, len_s;
  logic               ovl_r, ovl_s;
  logic [CNT_W-1:0]   count_s;
  logic               err_s, y_s, ready_s, busy_s, xfer_s;

  // Next-state computation: bit shifting, match detection, FSM, config.
  always_comb begin
    state_s     = state_r;
    bits_left_s = bits_left_r;
    sreg_s      = sreg_r;
    hist_s      = hist_r;
    fill_s      = fill_r;
    pat_s       = pat_r;
    len_s       = len_r;
    ovl_s       = ovl_r;
    count_s     = match_count;
    err_s       = err;
    y_s         = 1'b0;
    xfer_s      = word_valid && word_ready;

    // Consume one bit per cycle while the current word has bits left.
    if (bits_left_r != '0) begin
      hist_s      = {hist_r[PAT_MAX-2:0], sreg_r[WORD_W-1]};
      sreg_s      = {sreg_r[WORD_W-2:0], 1'b0};
      bits_left_s = bits_left_r - BL_ONE;
      fill_s      = (fill_r >= PAT_MAX4) ? PAT_MAX4 : (fill_r + 4'd1);
      if ((fill_s >= len_r) && (((hist_s ^ pat_r) & len_mask(len_r)) == '0)) begin
        y_s     = 1'b1;
        count_s = (&match_count) ? match_count : (match_count + CNT_W'(1));
        if (!ovl_r) begin
          fill_s = 4'd0;
        end else begin
          fill_s = fill_s;
        end
      end else begin
        y_s = 1'b0;
      end
    end else begin
      hist_s = hist_r;
    end

    // A new word may load on the same edge the last bit of the old one shifts.
    if (xfer_s) begin
      sreg_s      = word_data;
      bits_left_s = WORD_W_BL;
    end else begin
      sreg_s = sreg_s;
    end

    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = RUN;
          hist_s  = '0;
          fill_s  = 4'd0;
          count_s = '0;
          err_s   = 1'b0;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (stop) begin
          state_s = DRAIN;
        end else begin
          state_s = RUN;
        end
      end
      DRAIN: begin
        if (bits_left_r == '0) begin
          state_s = IDLE;
        end else begin
          state_s = DRAIN;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    // Config writes are accepted only in IDLE with a legal length.
    if (cfg_we) begin
      if (state_r != IDLE) begin
        err_s = 1'b1;
      end else if ((cfg_len == 4'd0) || (cfg_len > PAT_MAX4)) begin
        err_s = 1'b1;
      end else begin
        pat_s = cfg_pattern;
        len_s = cfg_len;
        ovl_s = cfg_overlap;
      end
    end else begin
      pat_s = pat_s;
    end

    ready_s = (state_s == RUN) && (bits_left_s <= BL_ONE);
    busy_s  = (state_s != IDLE);
  end

  // State and output registers; reset restores the default 1011 pattern.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      bits_left_r <= '0;
      sreg_r      <= '0;
      hist_r      <= '0;
      fill_r      <= 4'd0;
      pat_r       <= PAT_MAX'(4'b1011);
      len_r       <= 4'd4;
      ovl_r       <= 1'b1;
      match_count <= '0;
      err         <= 1'b0;
      y           <= 1'b0;
      word_ready  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_r     <= state_s;
      bits_left_r <= bits_left_s;
      sreg_r      <= sreg_s;
      hist_r      <= hist_s;
      fill_r      <= fill_s;
      pat_r       <= pat_s;
      len_r       <= len_s;
      ovl_r       <= ovl_s;
      match_count <= count_s;
      err         <= err_s;
      y           <= y_s;
      word_ready  <= ready_s;
      busy        <= busy_s;
    end
  end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Directed bench for pattern_scan_ctrl: match pulses are checked by a
// scoreboard monitor (expected cycle and count), control outputs directly.
`timescale 1ns/1ps
module tb_pattern_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_we = 1'b0;
  logic [7:0] cfg_pattern = 8'b0000_1011;
  logic [3:0] cfg_len = 4'd4;
  logic       cfg_overlap = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       word_valid = 1'b0;
  logic [7:0] word_data = 8'h00;
  logic       word_ready, y, busy, err;
  logic [1:0] match_count;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct { int cyc; int cnt; } exp_t;
  exp_t sbq[$];

  pattern_scan_ctrl #(.WORD_W(8), .PAT_MAX(8), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .start(start), .stop(stop),
    .word_valid(word_valid), .word_data(word_data), .word_ready(word_ready),
    .y(y), .match_count(match_count), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every y pulse must match the next expected (cycle, count).
  always @(negedge clk) begin : mon
    exp_t e;
    if (y === 1'b1) begin
      checks++;
      if (sbq.size() == 0) begin
        failures++;
        $display("FAIL y_unexpected: pulse at cyc %0d count %0d, none expected", cyc, match_count);
      end else begin
        e = sbq.pop_front();
        if (e.cyc != cyc || e.cnt != int'(match_count)) begin
          failures++;
          $display("FAIL y_pulse: got cyc %0d count %0d expected cyc %0d count %0d",
                   cyc, match_count, e.cyc, e.cnt);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic push(input int c, input int n);
    exp_t e;
    e.cyc = c;
    e.cnt = n;
    sbq.push_back(e);
  endtask

  // Present a word and wait (bounded) for its transfer edge; p = that edge's cycle.
  task automatic send_word(input logic [7:0] d, output int p);
    int n;
    word_valid = 1'b1;
    word_data  = d;
    n = 0;
    while (word_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (word_ready !== 1'b1) begin
      chk("ready_timeout", 0, 1);
      p = -100;
    end else begin
      @(posedge clk);
      #1;
      p = cyc;
      @(negedge clk);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic go_idle();
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    tick(3);
  endtask

  task automatic load_cfg(input logic [7:0] pat, input logic [3:0] len, input logic ovl);
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ovl;
    cfg_we      = 1'b1;
    tick(1);
    cfg_we      = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p, p2, p3;
    tick(3);
    chk("rst_busy", busy, 0);
    chk("rst_ready", word_ready, 0);
    chk("rst_y", y, 0);
    chk("rst_count", match_count, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    tick(1);

    // Reset defaults, overlapping: matches after bits 4 and 7.
    pulse_start();
    chk("busy_run", busy, 1);
    send_word(8'b1011_0110, p);
    word_valid = 1'b0;
    push(p + 4, 1);
    push(p + 7, 2);
    tick(10);
    chk("t1_count", match_count, 2);
    chk("t1_drained", sbq.size(), 0);
    go_idle();
    chk("t1_idle", busy, 0);

    // Non-overlapping: single match after bit 4.
    load_cfg(8'b0000_1011, 4'd4, 1'b0);
    chk("cfg_ok_err", err, 0);
    pulse_start();
    send_word(8'b1011_0110, p);
    word_valid = 1'b0;
    push(p + 4, 1);
    tick(10);
    chk("t2_count", match_count, 1);
    chk("t2_drained", sbq.size(), 0);
    go_idle();

    // Back-to-back words, match spanning the boundary.
    load_cfg(8'b0000_1011, 4'd4, 1'b1);
    pulse_start();
    send_word(8'b0000_0101, p);
    send_word(8'b1000_0000, p2);
    word_valid = 1'b0;
    chk("no_bubble", p2 - p, 8);
    push(p2 + 1, 1);
    tick(10);
    chk("t3_count", match_count, 1);
    chk("t3_drained", sbq.size(), 0);
    go_idle();

    // Config errors: illegal length in IDLE, any write in RUN.
    load_cfg(8'b0000_0011, 4'd0, 1'b0);
    chk("err_len0", err, 1);
    pulse_start();
    chk("err_cleared", err, 0);
    load_cfg(8'b0000_0001, 4'd2, 1'b0);
    chk("err_run_we", err, 1);
    send_word(8'b1011_0110, p);
    word_valid = 1'b0;
    push(p + 4, 1);
    push(p + 7, 2);
    tick(10);
    chk("t4_count", match_count, 2);
    chk("t4_drained", sbq.size(), 0);
    chk("err_sticky", err, 1);

    // Stop three bits into a word: five more busy cycles, then IDLE.
    send_word(8'h00, p);
    word_valid = 1'b0;
    tick(3);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    word_valid = 1'b1;
    word_data  = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      chk("drain_busy", busy, 1);
      chk("drain_ready", word_ready, 0);
      tick(1);
    end
    chk("drain_done", busy, 0);
    word_valid = 1'b0;
    chk("idle_count_hold", match_count, 2);
    chk("t5_drained", sbq.size(), 0);

    // Saturation at 3, then asynchronous reset mid-word.
    pulse_start();
    chk("start_clr_err", err, 0);
    send_word(8'b1011_0110, p);
    push(p + 4, 1);
    push(p + 7, 2);
    send_word(8'b1101_1011, p2);
    push(p2 + 2, 3);
    push(p2 + 5, 3);
    push(p2 + 8, 3);
    send_word(8'b1011_0110, p3);
    word_valid = 1'b0;
    tick(1);
    chk("sat_count", match_count, 3);
    chk("t6_drained", sbq.size(), 0);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_ready", word_ready, 0);
    chk("arst_y", y, 0);
    chk("arst_count", match_count, 0);
    chk("arst_err", err, 0);
    tick(2);
    rst = 1'b0;
    tick(2);
    chk("post_rst_idle", busy, 0);
    chk("post_rst_y", y, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
